// File: rtl/bram_pkg.sv
// Shared constants, FSM state type and sizing helper for the cascaded SDP RAM.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bram_state_e;

  // Aspect-ratio codes kept for the future primitive mapping layer.
  localparam logic [2:0] MODE_36 = 3'd0;
  localparam logic [2:0] MODE_18 = 3'd1;
  localparam logic [2:0] MODE_9  = 3'd2;
  localparam logic [2:0] MODE_4  = 3'd3;
  localparam logic [2:0] MODE_2  = 3'd4;
  localparam logic [2:0] MODE_1  = 3'd5;

  function automatic int lanes_of(input int width);
    return (width + 8) / 9;
  endfunction

endpackage

// File: rtl/bram_sdp_cascade_if.sv
// Request/response bundle between user logic and the cascaded SDP RAM.
interface bram_sdp_cascade_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 4
);

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [LANES-1:0]      be;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  ready;
  logic                  busy;

  modport master (
    output wen, waddr, wdata, be, ren, raddr,
    input  rdata, rvalid, ready, busy
  );

  modport slave (
    input  wen, waddr, wdata, be, ren, raddr,
    output rdata, rvalid, ready, busy
  );

endinterface

// File: rtl/bram_sdp_bank.sv
// One RAM bank: lane-enabled write, registered read, optional write-first bypass.
module bram_sdp_bank
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ABITS      = 10,
  parameter int LANES      = 4,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ABITS-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      be,
  input  logic                  re,
  input  logic [ABITS-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ABITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      wmask[i] = be[i / 9];
    end
  end

  assign old_word = mem[raddr];

  // Read-first falls out of the memory read preceding the write on the same edge.
  always_comb begin
    rd_word = old_word;
    if (RDW_MODE == RDW_WRITE_FIRST && we && (waddr == raddr)) begin
      rd_word = (old_word & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_word;
    end
  end

endmodule

// File: rtl/bram_sdp_cascade.sv
// Cascaded simple-dual-port RAM: clear sequencer, bank decode, read pipeline.
//  state | meaning
//  CLEAR | zero-filling one location per cycle, requests ignored
//  READY | accepting reads and writes
module bram_sdp_cascade
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int ADDR_WIDTH     = 12,
  parameter int BANK_ABITS     = 10,
  parameter int OUT_REG        = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst_n,
  bram_sdp_cascade_if.slave bus
);

  localparam int LANES     = lanes_of(DATA_WIDTH);
  localparam int NUM_BANKS = 1 << (ADDR_WIDTH - BANK_ABITS);
  localparam int BSEL_W    = (NUM_BANKS > 1) ? (ADDR_WIDTH - BANK_ABITS) : 1;
  localparam bram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  bram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready, busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = READY;
      end
      READY: ready = 1'b1;
      default: state_d = RST_STATE;
    endcase
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;

  // The clear sequencer owns the write port while busy.
  logic                  wr_en, rd_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_be;

  assign wr_en   = busy | (bus.wen & ready);
  assign wr_addr = busy ? clr_cnt_q : bus.waddr;
  assign wr_data = busy ? '0 : bus.wdata;
  assign wr_be   = busy ? '1 : bus.be;
  assign rd_acc  = bus.ren & ready;

  logic [BSEL_W-1:0] wr_bsel, rd_bsel, bsel1_q;

  if (NUM_BANKS > 1) begin : g_bsel
    assign wr_bsel = wr_addr[ADDR_WIDTH-1:BANK_ABITS];
    assign rd_bsel = bus.raddr[ADDR_WIDTH-1:BANK_ABITS];
  end else begin : g_bsel_one
    assign wr_bsel = '0;
    assign rd_bsel = '0;
  end

  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bram_sdp_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ABITS      (BANK_ABITS),
      .LANES      (LANES),
      .RDW_MODE   (RDW_MODE)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en && (wr_bsel == BSEL_W'(b))),
      .waddr (wr_addr[BANK_ABITS-1:0]),
      .wdata (wr_data),
      .be    (wr_be),
      .re    (rd_acc && (rd_bsel == BSEL_W'(b))),
      .raddr (bus.raddr[BANK_ABITS-1:0]),
      .rdata (bank_rd[b])
    );
  end

  logic v1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      bsel1_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) bsel1_q <= rd_bsel;
    end
  end

  logic [DATA_WIDTH-1:0] rd_mux;

  if (NUM_BANKS > 1) begin : g_mux
    assign rd_mux = bank_rd[bsel1_q];
  end else begin : g_mux_one
    assign rd_mux = bank_rd[0];
  end

  // Bank registers and bsel1_q only move on an accepted read, so the
  // unregistered path holds its last value on its own.
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= v1_q;
        if (v1_q) rdata_q <= rd_mux;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end else begin : g_noreg
    assign bus.rdata  = rd_mux;
    assign bus.rvalid = v1_q;
  end

endmodule

// File: tb/tb_bram_sdp_cascade.sv
// Directed bench: clear timing, lanes, latency, bank crossing, read-during-write.
module tb_bram_sdp_cascade;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // a: 4 banks of 4 words, registered output, read-first
  bram_sdp_cascade_if #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .LANES(4)) if_a ();
  // b: unregistered output, write-first
  bram_sdp_cascade_if #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .LANES(4)) if_b ();
  // c: 12-bit words (partial top lane), 4 banks of 1024
  bram_sdp_cascade_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12), .LANES(2)) if_c ();

  bram_sdp_cascade #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .BANK_ABITS(2), .OUT_REG(1),
                     .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  bram_sdp_cascade #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .BANK_ABITS(2), .OUT_REG(0),
                     .RDW_MODE(1), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  bram_sdp_cascade #(.DATA_WIDTH(12), .ADDR_WIDTH(12), .BANK_ABITS(10), .OUT_REG(1),
                     .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  typedef struct {
    string       name;
    logic        wen;
    logic [3:0]  waddr;
    logic [35:0] wdata;
    logic [3:0]  be;
    logic        ren;
    logic [3:0]  raddr;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    if_a.wen = 1'b0; if_a.waddr = '0; if_a.wdata = '0; if_a.be = '0; if_a.ren = 1'b0; if_a.raddr = '0;
    if_b.wen = 1'b0; if_b.waddr = '0; if_b.wdata = '0; if_b.be = '0; if_b.ren = 1'b0; if_b.raddr = '0;
    if_c.wen = 1'b0; if_c.waddr = '0; if_c.wdata = '0; if_c.be = '0; if_c.ren = 1'b0; if_c.raddr = '0;
  endtask

  int cnt;
  int rv_seen;

  initial begin
    vecs[0]  = '{"rd_clr_3",   1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd3,  36'h0};
    vecs[1]  = '{"rd_clr_15",  1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd15, 36'h0};
    vecs[2]  = '{"wr5_ones",   1'b1, 4'd5,  36'hFFFFFFFFF, 4'hF,    1'b0, 4'd0,  36'h0};
    vecs[3]  = '{"wr5_be0101", 1'b1, 4'd5,  36'h0,         4'b0101, 1'b0, 4'd0,  36'h0};
    vecs[4]  = '{"rd5_lanes",  1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd5,  36'hFF803FE00};
    vecs[5]  = '{"wr7_aa",     1'b1, 4'd7,  36'hAA,        4'hF,    1'b0, 4'd0,  36'h0};
    vecs[6]  = '{"rdw7_rf",    1'b1, 4'd7,  36'h55,        4'hF,    1'b1, 4'd7,  36'hAA};
    vecs[7]  = '{"rd7_after",  1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd7,  36'h55};
    vecs[8]  = '{"wr8_lane1",  1'b1, 4'd8,  36'h123456789, 4'b0010, 1'b0, 4'd0,  36'h0};
    vecs[9]  = '{"rd8_lane1",  1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd8,  36'h000016600};
    vecs[10] = '{"wr13_rd12",  1'b1, 4'd13, 36'h0DEADBEEF, 4'hF,    1'b1, 4'd12, 36'h0};
    vecs[11] = '{"rd13",       1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd13, 36'h0DEADBEEF};
    vecs[12] = '{"wr13_be0",   1'b1, 4'd13, 36'hFFFFFFFFF, 4'h0,    1'b0, 4'd0,  36'h0};
    vecs[13] = '{"rd13_keep",  1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd13, 36'h0DEADBEEF};
    vecs[14] = '{"rd_clr_0",   1'b0, 4'd0,  36'h0,         4'h0,    1'b1, 4'd0,  36'h0};

    idle_all();
    // requests held on a throughout the clear must all be dropped
    if_a.ren = 1'b1; if_a.raddr = 4'd0;
    if_a.wen = 1'b1; if_a.waddr = 4'd3; if_a.wdata = 36'hFFFFFFFFF; if_a.be = 4'hF;
    rst_n = 1'b0;
    step();
    step();
    check("reset_busy",   36'(if_a.busy),   36'h1);
    check("reset_ready",  36'(if_a.ready),  36'h0);
    check("reset_rvalid", 36'(if_a.rvalid), 36'h0);
    check("reset_rdata",  if_a.rdata,       36'h0);
    check("reset_rdata_b", if_b.rdata,      36'h0);

    rst_n = 1'b1;
    repeat (6) step();
    check("busy_mid_clear", 36'(if_a.busy), 36'h1);
    rst_n = 1'b0;
    step();
    check("busy_in_reset", 36'(if_a.busy), 36'h1);
    step();
    rst_n = 1'b1;

    cnt = 0;
    rv_seen = 0;
    while (if_a.busy && cnt < 100) begin
      if (if_a.rvalid) rv_seen++;
      step();
      cnt++;
    end
    if_a.wen = 1'b0;
    check("clear_cycles",        36'(cnt),         36'd16);
    check("rvalid_during_clear", 36'(rv_seen),     36'd0);
    check("ready_after_clear",   36'(if_a.ready),  36'h1);
    check("rvalid_at_ready",     36'(if_a.rvalid), 36'h0);
    check("ready_b",             36'(if_b.ready),  36'h1);
    step();
    if_a.ren = 1'b0;
    check("first_read_cycle1", 36'(if_a.rvalid), 36'h0);
    step();
    check("first_read_valid", 36'(if_a.rvalid), 36'h1);
    check("first_read_data",  if_a.rdata,       36'h0);
    step();
    check("first_read_single", 36'(if_a.rvalid), 36'h0);

    cnt = 0;
    while (!if_c.ready && cnt < 5000) begin
      step();
      cnt++;
    end
    check("c_ready", 36'(if_c.ready), 36'h1);
    check("c_busy",  36'(if_c.busy),  36'h0);

    for (int i = 0; i < 15; i++) begin
      if_a.wen = vecs[i].wen; if_a.waddr = vecs[i].waddr; if_a.wdata = vecs[i].wdata;
      if_a.be = vecs[i].be; if_a.ren = vecs[i].ren; if_a.raddr = vecs[i].raddr;
      step();
      if_a.wen = 1'b0;
      if_a.ren = 1'b0;
      if (vecs[i].ren) begin
        step();
        check({vecs[i].name, "_vld"}, 36'(if_a.rvalid), 36'h1);
        check(vecs[i].name, if_a.rdata, vecs[i].exp);
      end
    end

    // b: write-first with lane merge, latency 1, output hold
    if_b.wen = 1'b1; if_b.waddr = 4'd7; if_b.wdata = 36'hAA; if_b.be = 4'hF;
    step();
    if_b.wdata = 36'h55; if_b.ren = 1'b1; if_b.raddr = 4'd7;
    step();
    if_b.wen = 1'b0; if_b.ren = 1'b0;
    check("b_rdw_wf_vld", 36'(if_b.rvalid), 36'h1);
    check("b_rdw_wf",     if_b.rdata,       36'h55);
    if_b.wen = 1'b1; if_b.waddr = 4'd9; if_b.wdata = 36'hFFFFFFFFF; if_b.be = 4'hF;
    step();
    if_b.wdata = 36'h0; if_b.be = 4'b0101; if_b.ren = 1'b1; if_b.raddr = 4'd9;
    step();
    if_b.wen = 1'b0; if_b.ren = 1'b0;
    check("b_rdw_merge", if_b.rdata, 36'hFF803FE00);
    step();
    check("b_hold_vld",  36'(if_b.rvalid), 36'h0);
    check("b_hold_data", if_b.rdata,       36'hFF803FE00);
    if_b.ren = 1'b1; if_b.raddr = 4'd9;
    step();
    if_b.ren = 1'b0;
    check("b_merged_stored", if_b.rdata, 36'hFF803FE00);

    // c: bank crossing with back-to-back reads, partial top lane
    if_c.wen = 1'b1; if_c.be = 2'b11;
    if_c.waddr = 12'h3FF; if_c.wdata = 12'h123;
    step();
    if_c.waddr = 12'h400; if_c.wdata = 12'h456;
    step();
    if_c.waddr = 12'h001; if_c.wdata = 12'hFFF; if_c.be = 2'b10;
    step();
    if_c.wen = 1'b0;
    if_c.ren = 1'b1; if_c.raddr = 12'h3FF;
    step();
    if_c.raddr = 12'h400;
    check("c_lat_cycle1", 36'(if_c.rvalid), 36'h0);
    step();
    if_c.ren = 1'b0;
    check("c_rd0_vld",  36'(if_c.rvalid), 36'h1);
    check("c_rd0_data", 36'(if_c.rdata),  36'h123);
    step();
    check("c_rd1_vld",  36'(if_c.rvalid), 36'h1);
    check("c_rd1_data", 36'(if_c.rdata),  36'h456);
    step();
    check("c_hold_vld",  36'(if_c.rvalid), 36'h0);
    check("c_hold_data", 36'(if_c.rdata),  36'h456);
    if_c.ren = 1'b1; if_c.raddr = 12'h001;
    step();
    if_c.raddr = 12'hFFF;
    step();
    if_c.ren = 1'b0;
    check("c_partial_lane", 36'(if_c.rdata), 36'hE00);
    step();
    check("c_last_addr", 36'(if_c.rdata), 36'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
